// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // One buffered fetch: address and the word read from it.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: circular FIFO with flush, head reads zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         count,
  output fetch_entry_t                   head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;

  // Pointer/count bookkeeping; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is datapath only; validity comes from count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction fetch with redirect and a small decoupling buffer.
// Optional misaligned-redirect fault detection: INSTR_FETCH_MISALIGN_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              push;
  logic              pop;
  logic              flush;
  logic              full;
  logic              misalign;
  logic [31:0]       target_pc;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  assign misalign  = (redirect_pc[1:0] != 2'b00);
  assign target_pc = redirect_pc;
`else
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign misalign       = 1'b0;
  assign target_pc      = {redirect_pc[31:2], 2'b00};
`endif

  assign pop       = out_valid & out_ready;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign push_data = '{pc: pc_q, instr: imem_rdata};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state: a faulting redirect is terminal until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && redirect_valid && misalign) state_d = ST_FAULT;
  end

  // Fetch control: redirect beats sequential fetch; FAULT only drains.
  always_comb begin
    push  = 1'b0;
    pc_d  = pc_q;
    flush = redirect_valid;
    if (state_q == ST_RUN) begin
      if (redirect_valid) begin
        if (!misalign) pc_d = target_pc;
      end else if (!full || pop) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  assign fault = (state_q == ST_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch, plus a free-running handshake stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ea, input logic ef);
    vec_t v;
    v.rst_n = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea; v.exp_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vectors();
    logic [31:0] exp_instr;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n          = vecs[i].rst_n;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      #1;
      exp_instr = vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("row%0d out_pc", i),    out_pc,         vecs[i].exp_pc);
      chk($sformatf("row%0d out_instr", i), out_instr,      exp_instr);
      chk($sformatf("row%0d imem_addr", i), imem_addr,      vecs[i].exp_addr);
      chk($sformatf("row%0d fault", i),     32'(fault),     32'(vecs[i].exp_fault));
    end
  endtask

  // Ready toggles irregularly; expected PC advances only on a completed handshake.
  task automatic run_stream();
    logic [31:0] exp_pc;
    logic        seen;
    int          wait_cycles;
    exp_pc      = 32'hBFC0_0000;
    seen        = 1'b0;
    wait_cycles = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk);
      #1;
      rst_n          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = (c % 3) != 1;
      #1;
      if (seen) begin
        chk($sformatf("stream c%0d out_valid", c), 32'(out_valid), 32'd1);
      end
      if (out_valid) begin
        seen = 1'b1;
        chk($sformatf("stream c%0d out_pc", c),    out_pc,    exp_pc);
        chk($sformatf("stream c%0d out_instr", c), out_instr, mem_word(exp_pc));
        if (out_ready) exp_pc = exp_pc + 32'd4;
      end else if (!seen) begin
        wait_cycles++;
        if (wait_cycles > 3) begin
          chk("stream first valid timeout", 32'(out_valid), 32'd1);
          break;
        end
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Reset release, streaming with ready high.
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00000, 32'hBFC00004, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00004, 32'hBFC00008, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00008, 32'hBFC0000C, 0));
    // Reset, then ready low for five cycles: buffer fills and PC stalls.
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'hBFC00000, 32'hBFC00004, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'hBFC00000, 32'hBFC00008, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'hBFC00000, 32'hBFC00008, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'hBFC00000, 32'hBFC00008, 0));
    // Redirect while full with a pop in the same cycle.
    vecs.push_back(mk(1, 1, 32'hBFC00100, 1, 1, 32'hBFC00000, 32'hBFC00008, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00100, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00100, 32'hBFC00104, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'hBFC00104, 32'hBFC00108, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'hBFC00104, 32'hBFC0010C, 0));
    // Reset pulse with two entries buffered.
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00000, 32'hBFC00004, 0));
    // Redirect near the top of the address space: PC wraps to zero.
    vecs.push_back(mk(1, 1, 32'hFFFFFFF8, 1, 1, 32'hBFC00004, 32'hBFC00008, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'hFFFFFFF8, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hFFFFFFF8, 32'hFFFFFFFC, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hFFFFFFFC, 32'h00000000, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'h00000000, 32'h00000004, 0));
    // Misaligned redirect.
    vecs.push_back(mk(1, 1, 32'hBFC00102, 1, 1, 32'h00000004, 32'h00000008, 0));
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'h00000008, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'h00000008, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'h00000008, 1));
`else
    vecs.push_back(mk(1, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00100, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00100, 32'hBFC00104, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 32'hBFC00104, 32'hBFC00108, 0));
`endif
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,         32'hBFC00000, 0));

    run_vectors();
    run_stream();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
